// File: rtl/pop_sorter_topk.sv
// Top-K population sorter: latches N distances and emits the K smallest indices by iterative min-select.
// Optional build macro POP_SORTER_DESCEND_EN adds a descend input that selects the largest entries instead.
module pop_sorter_topk #(
   parameter int N      = 50,
   parameter int DIST_W = 12,
   parameter int K      = N,
   parameter int IDX_W  = $clog2(N)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
`ifdef POP_SORTER_DESCEND_EN
   input  logic                  descend,
`endif
   input  logic [N*DIST_W-1:0]   in,
   output logic [K*IDX_W-1:0]    sorted,
   output logic [DIST_W-1:0]     best_value,
   output logic                  busy,
   output logic                  done
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t              r_state;
   state_t              w_next;
   logic [IDX_W:0]      r_cnt;
   logic [DIST_W-1:0]   r_dist [N];
   logic [N-1:0]        r_valid;
   logic [K*IDX_W-1:0]  r_sorted;
   logic [DIST_W-1:0]   r_best;
   logic                w_desc;
   logic                w_load;
   logic                w_take;
   logic                w_found;
   logic [IDX_W-1:0]    w_sel_idx;
   logic [DIST_W-1:0]   w_sel_val;

`ifdef POP_SORTER_DESCEND_EN
   logic r_desc;
   assign w_desc = r_desc;
`else
   assign w_desc = 1'b0;
`endif

   // Strict compare keeps the earliest index on ties; valid flags mask consumed entries.
   always_comb begin
      w_found   = 1'b0;
      w_sel_idx = '0;
      w_sel_val = '0;
      for (int unsigned i = 0; i < N; i++) begin
         if (r_valid[i] && (!w_found ||
             (w_desc ? (r_dist[i] > w_sel_val) : (r_dist[i] < w_sel_val)))) begin
            w_found   = 1'b1;
            w_sel_idx = IDX_W'(i);
            w_sel_val = r_dist[i];
         end
      end
   end

   always_comb begin
      w_next = r_state;
      w_load = 1'b0;
      w_take = 1'b0;
      case (r_state)
         IDLE, DONE: begin
            if (start) begin
               w_load = 1'b1;
               w_next = SCAN;
            end
         end
         SCAN: begin
            w_take = w_found;
            if (r_cnt == (IDX_W+1)'(K-1))
               w_next = DONE;
         end
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_state <= IDLE;
      else
         r_state <= w_next;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt    <= '0;
         r_valid  <= '0;
         r_sorted <= '0;
         r_best   <= '0;
         for (int unsigned i = 0; i < N; i++)
            r_dist[i] <= '0;
`ifdef POP_SORTER_DESCEND_EN
         r_desc   <= 1'b0;
`endif
      end else if (w_load) begin
         r_cnt   <= '0;
         r_valid <= '1;
         for (int unsigned i = 0; i < N; i++)
            r_dist[i] <= in[i*DIST_W +: DIST_W];
`ifdef POP_SORTER_DESCEND_EN
         r_desc  <= descend;
`endif
      end else if (w_take) begin
         for (int unsigned r = 0; r < K; r++) begin
            if (r_cnt == (IDX_W+1)'(r))
               r_sorted[r*IDX_W +: IDX_W] <= w_sel_idx;
         end
         for (int unsigned i = 0; i < N; i++) begin
            if (w_sel_idx == IDX_W'(i))
               r_valid[i] <= 1'b0;
         end
         if (r_cnt == '0)
            r_best <= w_sel_val;
         r_cnt <= r_cnt + (IDX_W+1)'(1);
      end
   end

   assign sorted     = r_sorted;
   assign best_value = r_best;
   assign busy       = (r_state == SCAN);
   assign done       = (r_state == DONE);

endmodule

// File: tb/tb_pop_sorter_topk.sv
// Scoreboard bench for pop_sorter_topk: K=4 and K=2 instances over N=4, 8-bit distances.
module tb_pop_sorter_topk;

`ifdef POP_SORTER_DESCEND_EN
   localparam bit HAS_DESC = 1'b1;
`else
   localparam bit HAS_DESC = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start1 = 1'b0;
   logic        start2 = 1'b0;
   logic        descend = 1'b0;
   logic [31:0] in_bus = '0;
   logic [7:0]  sorted1;
   logic [3:0]  sorted2;
   logic [7:0]  best1, best2;
   logic        busy1, busy2, done1, done2;

   always #5 clk = ~clk;

   pop_sorter_topk #(.N(4), .DIST_W(8), .K(4)) u_dut1 (
      .clk(clk), .rst(rst), .start(start1),
`ifdef POP_SORTER_DESCEND_EN
      .descend(descend),
`endif
      .in(in_bus), .sorted(sorted1), .best_value(best1), .busy(busy1), .done(done1)
   );

   pop_sorter_topk #(.N(4), .DIST_W(8), .K(2)) u_dut2 (
      .clk(clk), .rst(rst), .start(start2),
`ifdef POP_SORTER_DESCEND_EN
      .descend(descend),
`endif
      .in(in_bus), .sorted(sorted2), .best_value(best2), .busy(busy2), .done(done2)
   );

   typedef struct packed {
      logic [7:0] srt;
      logic [7:0] best;
   } exp_t;

   exp_t q1[$];
   exp_t q2[$];
   exp_t e1, e2;
   int   n_vec = 0;
   int   n_err = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Rank of entry i = number of entries that beat it (better value, or equal value at lower index).
   function automatic exp_t model(input logic [7:0] v[4], input logic desc, input int kk);
      exp_t e;
      int   r;
      e = '0;
      for (int i = 0; i < 4; i++) begin
         r = 0;
         for (int j = 0; j < 4; j++) begin
            if ((desc ? (v[j] > v[i]) : (v[j] < v[i])) || (v[j] == v[i] && j < i))
               r++;
         end
         if (r < kk) e.srt[r*2 +: 2] = 2'(i);
         if (r == 0) e.best = v[i];
      end
      return e;
   endfunction

   // Monitor: pops an expectation on every rising done and checks ranks, best value and busy length.
   logic pd1 = 1'b0, pd2 = 1'b0;
   int   bc1 = 0, bc2 = 0;
   always @(negedge clk) begin
      if (rst) begin
         bc1 = 0;
         bc2 = 0;
      end else begin
         if (busy1) bc1++;
         if (busy2) bc2++;
         if (done1 && !pd1) begin
            if (q1.size() == 0) begin
               n_vec++; n_err++;
               $display("FAIL k4_unexpected_done: got done, expected none");
            end else begin
               e1 = q1.pop_front();
               chk("k4_sorted", 32'(sorted1), 32'(e1.srt));
               chk("k4_best", 32'(best1), 32'(e1.best));
               chk("k4_busy_cycles", bc1, 4);
            end
            bc1 = 0;
         end
         if (done2 && !pd2) begin
            if (q2.size() == 0) begin
               n_vec++; n_err++;
               $display("FAIL k2_unexpected_done: got done, expected none");
            end else begin
               e2 = q2.pop_front();
               chk("k2_sorted", 32'(sorted2), 32'(e2.srt[3:0]));
               chk("k2_best", 32'(best2), 32'(e2.best));
               chk("k2_busy_cycles", bc2, 2);
            end
            bc2 = 0;
         end
      end
      pd1 = done1;
      pd2 = done2;
   end

   task automatic issue(input logic [7:0] v[4], input logic desc, input bit use2);
      in_bus  = {v[3], v[2], v[1], v[0]};
      descend = desc;
      start1  = 1'b1;
      start2  = use2;
      q1.push_back(model(v, desc, 4));
      if (use2) q2.push_back(model(v, desc, 2));
      @(negedge clk);
      start1  = 1'b0;
      start2  = 1'b0;
      in_bus  = $urandom;
   endtask

   task automatic wait_done;
      int c;
      for (c = 0; c < 20; c++) begin
         if (done1) break;
         @(negedge clk);
      end
      if (c == 20) begin
         n_vec++; n_err++;
         $display("FAIL wait_done: got no done within 20 cycles, expected done");
      end
   endtask

   logic [7:0] v[4];

   initial begin
      repeat (2) @(negedge clk);
      chk("rst_sorted", 32'(sorted1), 0);
      chk("rst_best", 32'(best1), 0);
      chk("rst_busy", 32'(busy1), 0);
      chk("rst_done", 32'(done1), 0);
      rst = 1'b0;
      @(negedge clk);

      v = '{8'd30, 8'd10, 8'd20, 8'd40};
      issue(v, 1'b0, 1'b1); wait_done();
      v = '{8'd255, 8'd255, 8'd0, 8'd255};
      issue(v, 1'b0, 1'b1); wait_done();
      v = '{8'd7, 8'd7, 8'd7, 8'd7};
      issue(v, 1'b0, 1'b1); wait_done();

      // start during SCAN must be ignored
      v = '{8'd30, 8'd10, 8'd20, 8'd40};
      issue(v, 1'b0, 1'b0);
      in_bus = {8'd1, 8'd2, 8'd3, 8'd4};
      start1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0;
      wait_done();
      repeat (2) @(negedge clk);
      chk("done_hold", 32'(done1), 1);
      v = '{8'd4, 8'd3, 8'd2, 8'd1};
      issue(v, 1'b0, 1'b1); wait_done();

      // asynchronous reset after two ranks; aborted sort has no expectation
      in_bus = {8'd40, 8'd20, 8'd10, 8'd30};
      start1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0;
      repeat (2) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      chk("abort_sorted", 32'(sorted1), 0);
      chk("abort_best", 32'(best1), 0);
      chk("abort_busy", 32'(busy1), 0);
      chk("abort_done", 32'(done1), 0);
      @(negedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      v = '{8'd40, 8'd30, 8'd20, 8'd10};
      issue(v, 1'b0, 1'b1); wait_done();

      if (HAS_DESC) begin
         v = '{8'd30, 8'd10, 8'd20, 8'd40};
         issue(v, 1'b1, 1'b1); wait_done();
      end

      for (int t = 0; t < 40; t++) begin
         for (int i = 0; i < 4; i++)
            v[i] = ($urandom_range(0, 3) == 0) ? 8'hFF :
                   (t[0] ? 8'($urandom_range(0, 4)) : 8'($urandom));
         issue(v, HAS_DESC ? 1'($urandom_range(0, 1)) : 1'b0, 1'($urandom_range(0, 1)));
         wait_done();
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end

      repeat (3) @(negedge clk);
      chk("q1_drained", q1.size(), 0);
      chk("q2_drained", q2.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
